// File: rtl/hack_ctrl_pkg.sv
// hack_ctrl_pkg: shared states, command codes and helpers for the Hack run controller.
// HACK_BREAKPOINT_EN adds the breakpoint-trailer load states.
package hack_ctrl_pkg;

  localparam int DEF_ROM_DEPTH = 32768;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DAT_HI,
    S_DAT_LO,
    S_RUN,
    S_HALT
`ifdef HACK_BREAKPOINT_EN
    ,
    S_BP_EN,
    S_BP_HI,
    S_BP_LO
`endif
  } state_e;

`ifdef HACK_BREAKPOINT_EN
  localparam state_e S_LOAD_END = S_BP_EN;
`else
  localparam state_e S_LOAD_END = S_IDLE;
`endif

  function automatic logic is_load(input state_e s);
`ifdef HACK_BREAKPOINT_EN
    return s inside {S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO, S_BP_EN, S_BP_HI, S_BP_LO};
`else
    return s inside {S_HDR_HI, S_HDR_LO, S_DAT_HI, S_DAT_LO};
`endif
  endfunction

  // Second byte of a pair: completes a 16-bit word in the packer.
  function automatic logic is_lo(input state_e s);
`ifdef HACK_BREAKPOINT_EN
    return s inside {S_HDR_LO, S_DAT_LO, S_BP_LO};
`else
    return s inside {S_HDR_LO, S_DAT_LO};
`endif
  endfunction

endpackage

// File: rtl/hack_byte_packer.sv
// hack_byte_packer: pairs a held high byte with the incoming low byte into a 16-bit word.
module hack_byte_packer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        take,
  input  logic        lo,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [15:0] word
);

  logic [7:0] hold_q, hold_d;

  always_comb hold_d = (take && !lo) ? byte_in : hold_q;

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) hold_q <= '0;
    else hold_q <= hold_d;

  assign word_valid = take && lo;
  assign word = {hold_q, byte_in};

endmodule

// File: rtl/hack_run_controller.sv
// hack_run_controller: loads a program image into ROM over a byte stream, then runs/steps/halts the CPU.
// Define HACK_BREAKPOINT_EN for a load trailer that sets a PC breakpoint.
module hack_run_controller
  import hack_ctrl_pkg::*;
#(
  parameter int ROM_DEPTH = DEF_ROM_DEPTH,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  input  logic [14:0]       pc,
  output logic              cpu_reset,
  output logic              cpu_run,
  output logic              busy,
  output logic              load_done,
  output logic              load_err,
  output logic              halted
);

  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, rom_addr_q, rom_addr_d;
  logic [15:0] len_q, len_d, rom_wdata_q, rom_wdata_d;
  logic rx_ready_q, rx_ready_d, rom_we_q, rom_we_d, cpu_reset_q, cpu_reset_d;
  logic cpu_run_q, cpu_run_d, busy_q, busy_d, load_done_q, load_done_d;
  logic load_err_q, load_err_d, halted_q, halted_d;
  logic take, last, step_pulse, bp_hit, pk_valid;
  logic [15:0] pk_word;

  assign take = rx_valid && rx_ready_q;
  assign last = 17'(cnt_q) == 17'(len_q) - 17'd1;

  hack_byte_packer u_packer (
    .clk        (clk),
    .reset_n    (reset_n),
    .take       (take),
    .lo         (is_lo(state_q)),
    .byte_in    (rx_data),
    .word_valid (pk_valid),
    .word       (pk_word)
  );

`ifdef HACK_BREAKPOINT_EN
  logic bp_en_q, bp_en_d, skip_q, skip_d;
  logic [14:0] bp_addr_q, bp_addr_d;
  // Leaving HALT at the breakpoint must not re-trigger until pc moves off it.
  always_comb skip_d = (state_q == S_HALT) || (state_q == S_RUN && skip_q && pc == bp_addr_q);
  assign bp_hit = state_q == S_RUN && bp_en_q && pc == bp_addr_q && !skip_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bp_en_q <= 1'b0;
      bp_addr_q <= '0;
      skip_q <= 1'b0;
    end else begin
      bp_en_q <= bp_en_d;
      bp_addr_q <= bp_addr_d;
      skip_q <= skip_d;
    end
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    len_d = len_q;
    rom_we_d = 1'b0;
    rom_addr_d = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    load_done_d = 1'b0;
    load_err_d = load_err_q;
    step_pulse = 1'b0;
`ifdef HACK_BREAKPOINT_EN
    bp_en_d = bp_en_q;
    bp_addr_d = bp_addr_q;
`endif
    case (state_q)
      S_IDLE:
        if (cmd_valid && cmd == CMD_RUN) state_d = S_RUN;
        else if (cmd_valid && cmd == CMD_STEP) begin
          state_d = S_HALT;
          step_pulse = 1'b1;
        end
      S_RUN:
        if ((cmd_valid && (cmd == CMD_HALT || cmd == CMD_STEP)) || bp_hit) state_d = S_HALT;
      S_HALT:
        if (cmd_valid && cmd == CMD_RUN) state_d = S_RUN;
        else step_pulse = cmd_valid && cmd == CMD_STEP;
      S_HDR_HI:
        if (take) state_d = S_HDR_LO;
      S_HDR_LO:
        if (pk_valid) begin
          if (pk_word == 16'd0) state_d = S_IDLE;
          else if (17'(pk_word) > 17'(ROM_DEPTH)) begin
            load_err_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            len_d = pk_word;
            cnt_d = '0;
            state_d = S_DAT_HI;
          end
        end
      S_DAT_HI:
        if (take) state_d = S_DAT_LO;
      S_DAT_LO:
        if (pk_valid) begin
          rom_we_d = 1'b1;
          rom_addr_d = cnt_q;
          rom_wdata_d = pk_word;
          cnt_d = cnt_q + 1'b1;
          load_done_d = last;
          state_d = last ? S_LOAD_END : S_DAT_HI;
        end
`ifdef HACK_BREAKPOINT_EN
      S_BP_EN:
        if (take) begin
          bp_en_d = rx_data[7];
          state_d = S_BP_HI;
        end
      S_BP_HI:
        if (take) state_d = S_BP_LO;
      S_BP_LO:
        if (pk_valid) begin
          bp_addr_d = pk_word[14:0];
          state_d = S_IDLE;
        end
`endif
      default: state_d = S_IDLE;
    endcase
    // LOAD overrides everything outside the load states; inside them commands are dropped.
    if (cmd_valid && cmd == CMD_LOAD && !is_load(state_q)) begin
      state_d = S_HDR_HI;
      load_err_d = 1'b0;
      cnt_d = '0;
    end
    busy_d = is_load(state_d);
    rx_ready_d = busy_d;
    cpu_reset_d = state_d == S_IDLE || busy_d;
    cpu_run_d = state_d == S_RUN || step_pulse;
    halted_d = state_d == S_HALT;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      len_q <= '0;
      rx_ready_q <= 1'b0;
      rom_we_q <= 1'b0;
      rom_addr_q <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      cpu_run_q <= 1'b0;
      busy_q <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      len_q <= len_d;
      rx_ready_q <= rx_ready_d;
      rom_we_q <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      cpu_run_q <= cpu_run_d;
      busy_q <= busy_d;
      load_done_q <= load_done_d;
      load_err_q <= load_err_d;
      halted_q <= halted_d;
    end

  assign rx_ready = rx_ready_q;
  assign rom_we = rom_we_q;
  assign rom_addr = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign cpu_run = cpu_run_q;
  assign busy = busy_q;
  assign load_done = load_done_q;
  assign load_err = load_err_q;
  assign halted = halted_q;

endmodule

// File: tb/tb_hack_run_controller.sv
// tb_hack_run_controller: scoreboard bench for the Hack run controller; ROM writes checked against a queue.
module tb_hack_run_controller;
  import hack_ctrl_pkg::*;

  logic clk = 0, reset_n = 0, cmd_valid = 0, rx_valid = 0;
  logic [1:0] cmd = 2'b00;
  logic [7:0] rx_data = 8'h00;
  logic [14:0] pc;
  logic rx_ready, rom_we, cpu_reset, cpu_run, busy, load_done, load_err, halted;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  int total = 0, bad = 0;
  typedef struct packed {logic [14:0] a; logic [15:0] d; logic done;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  logic [15:0] img[$];
  bit win = 0;
  int run_cnt = 0, adj = 0, halt_bad = 0, rst_bad = 0;
  logic run_prev = 0;
`ifdef HACK_BREAKPOINT_EN
  logic [7:0] trl[3] = '{8'h00, 8'h00, 8'h00};
  int c5, ch;
  logic [14:0] p0;
`endif

  always #5 clk = ~clk;

  hack_run_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .pc        (pc),
    .cpu_reset (cpu_reset),
    .cpu_run   (cpu_run),
    .busy      (busy),
    .load_done (load_done),
    .load_err  (load_err),
    .halted    (halted)
  );

  // Minimal CPU: pc advances on every enabled clock, cleared by cpu_reset.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) pc <= '0;
    else if (cpu_reset) pc <= '0;
    else if (cpu_run) pc <= pc + 15'd1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n) begin
      if (rom_we) begin
        if (exp_q.size() == 0) check("rom_we_extra", 32'(rom_we), 32'(0));
        else begin
          mon_e = exp_q.pop_front();
          check("rom_addr", 32'(rom_addr), 32'(mon_e.a));
          check("rom_wdata", 32'(rom_wdata), 32'(mon_e.d));
          check("load_done", 32'(load_done), 32'(mon_e.done));
        end
      end else if (load_done) check("load_done_alone", 32'(load_done), 32'(0));
    end

  always @(negedge clk)
    if (win) begin
      run_cnt += int'(cpu_run);
      if (cpu_run && run_prev) adj++;
      if (!halted) halt_bad++;
      if (cpu_reset) rst_bad++;
      run_prev = cpu_run;
    end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd_pulse(input logic [1:0] c);
    cmd_valid = 1;
    cmd = c;
    tick(1);
    cmd_valid = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_cmd);
    int n = 0;
    rx_valid = 1;
    rx_data = b;
    if (with_cmd) begin
      cmd_valid = 1;
      cmd = CMD_RUN;
    end
    while (!rx_ready && n < 50) begin
      tick(1);
      n++;
    end
    if (!rx_ready) check("rx_ready_timeout", 32'(rx_ready), 32'(1));
    else tick(1);
    rx_valid = 0;
    cmd_valid = 0;
  endtask

  task automatic load_image(input logic [15:0] n, input int gaps, input int cmd_at);
    logic [7:0] tx[$];
    bit legal;
    legal = n != 16'd0 && n <= 16'h8000;
    cmd_pulse(CMD_LOAD);
    check("ld_busy", 32'(busy), 32'(1));
    check("ld_rx_ready", 32'(rx_ready), 32'(1));
    check("ld_cpu_reset", 32'(cpu_reset), 32'(1));
    check("ld_cpu_run", 32'(cpu_run), 32'(0));
    check("ld_err_clr", 32'(load_err), 32'(0));
    tx.push_back(n[15:8]);
    tx.push_back(n[7:0]);
    if (legal) begin
      for (int i = 0; i < int'(n); i++) begin
        tx.push_back(img[i][15:8]);
        tx.push_back(img[i][7:0]);
        exp_q.push_back(wr_t'{15'(i), img[i], 1'(i == int'(n) - 1)});
      end
`ifdef HACK_BREAKPOINT_EN
      for (int i = 0; i < 3; i++) tx.push_back(trl[i]);
`endif
    end
    for (int i = 0; i < tx.size(); i++) begin
      if (gaps > 0) repeat ($urandom_range(0, gaps)) tick(1);
      send_byte(tx[i], i == cmd_at);
      if (i == cmd_at) begin
        check("cmd_drop_run", 32'(cpu_run), 32'(0));
        check("cmd_drop_busy", 32'(busy), 32'(1));
      end
    end
    tick(1);
    check("end_busy", 32'(busy), 32'(0));
    check("end_rx_ready", 32'(rx_ready), 32'(0));
    check("end_cpu_reset", 32'(cpu_reset), 32'(1));
    check("end_err", 32'(load_err), 32'(!legal && n != 16'd0));
  endtask

  initial begin
    tick(2);
    check("rst_cpu_reset", 32'(cpu_reset), 32'(1));
    check("rst_cpu_run", 32'(cpu_run), 32'(0));
    check("rst_rx_ready", 32'(rx_ready), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_halted", 32'(halted), 32'(0));
    check("rst_load_err", 32'(load_err), 32'(0));
    check("rst_rom_we", 32'(rom_we), 32'(0));
    check("rst_load_done", 32'(load_done), 32'(0));
    reset_n = 1;
    tick(1);
    cmd_pulse(CMD_HALT);
    check("idle_halt_halted", 32'(halted), 32'(0));
    check("idle_halt_rst", 32'(cpu_reset), 32'(1));
    img = '{16'h1234, 16'hABCD};
    load_image(16'd2, 0, -1);
    load_image(16'h8001, 0, -1);
    load_image(16'h0000, 0, -1);
    img.delete();
    for (int i = 0; i < 5; i++) img.push_back(16'($urandom));
    load_image(16'd5, 2, 3);
    cmd_pulse(CMD_RUN);
    check("run_run", 32'(cpu_run), 32'(1));
    check("run_rst", 32'(cpu_reset), 32'(0));
    check("run_halted", 32'(halted), 32'(0));
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("run_hold", 32'(cpu_run), 32'(1));
    end
    cmd_pulse(CMD_RUN);
    check("run_ignore", 32'(cpu_run), 32'(1));
    cmd_pulse(CMD_HALT);
    check("halt_run", 32'(cpu_run), 32'(0));
    check("halt_halted", 32'(halted), 32'(1));
    check("halt_rst", 32'(cpu_reset), 32'(0));
    win = 1;
    for (int i = 0; i < 3; i++) begin
      cmd_pulse(CMD_STEP);
      tick(2);
    end
    win = 0;
    check("step_pulses", 32'(run_cnt), 32'(3));
    check("step_adjacent", 32'(adj), 32'(0));
    check("step_not_halted", 32'(halt_bad), 32'(0));
    check("step_cpu_reset", 32'(rst_bad), 32'(0));
    cmd_pulse(CMD_RUN);
    check("resume_run", 32'(cpu_run), 32'(1));
    check("resume_rst", 32'(cpu_reset), 32'(0));
    cmd_pulse(CMD_STEP);
    check("run_step_run", 32'(cpu_run), 32'(0));
    check("run_step_halted", 32'(halted), 32'(1));
    img = '{16'hBEEF};
    load_image(16'd1, 0, -1);
    cmd_pulse(CMD_STEP);
    check("idle_step_run", 32'(cpu_run), 32'(1));
    check("idle_step_rst", 32'(cpu_reset), 32'(0));
    check("idle_step_halted", 32'(halted), 32'(1));
    tick(1);
    check("idle_step_run_off", 32'(cpu_run), 32'(0));
    check("idle_step_halted2", 32'(halted), 32'(1));
    cmd_pulse(CMD_RUN);
    tick(2);
    #2 reset_n = 0;
    #1;
    check("arst_run_cpu_reset", 32'(cpu_reset), 32'(1));
    check("arst_run_cpu_run", 32'(cpu_run), 32'(0));
    check("arst_run_halted", 32'(halted), 32'(0));
    tick(1);
    reset_n = 1;
    tick(1);
    cmd_pulse(CMD_LOAD);
    exp_q.push_back(wr_t'{15'd0, 16'h1122, 1'b0});
    send_byte(8'h00, 0);
    send_byte(8'h03, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    #2 reset_n = 0;
    #1;
    check("arst_ld_rx_ready", 32'(rx_ready), 32'(0));
    check("arst_ld_rom_we", 32'(rom_we), 32'(0));
    check("arst_ld_busy", 32'(busy), 32'(0));
    check("arst_ld_cpu_reset", 32'(cpu_reset), 32'(1));
    tick(1);
    reset_n = 1;
    tick(1);
    img = '{16'h5566};
    load_image(16'd1, 1, -1);
`ifdef HACK_BREAKPOINT_EN
    trl = '{8'h80, 8'h00, 8'h05};
    img = '{16'h1111};
    load_image(16'd1, 0, -1);
    cmd_pulse(CMD_RUN);
    c5 = -1;
    ch = -1;
    for (int c = 0; c < 60; c++) begin
      if (pc == 15'd5 && c5 < 0) c5 = c;
      if (halted) begin
        ch = c;
        break;
      end
      tick(1);
    end
    check("bp_halt_delay", 32'(ch - c5), 32'(1));
    check("bp_cpu_run", 32'(cpu_run), 32'(0));
    p0 = pc;
    cmd_pulse(CMD_STEP);
    tick(1);
    check("bp_step_pc", 32'(pc), 32'(p0 + 15'd1));
    check("bp_step_halted", 32'(halted), 32'(1));
`endif
    tick(2);
    check("sb_empty", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
